// File: rtl/med_pkg.sv
// Shared types and schedule constants for the median filter sequencing controller.
package med_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SORT, CAPT} med_state_t;

  localparam int N_PIX      = 9;
  localparam int N_PASS     = 5;
  localparam int LAST_STEPS = 4;
  localparam int MED_LAT    = 49;

endpackage

// File: rtl/MED.sv
// Rotating compare-exchange datapath: a ring of SIZE taps with the running maximum
// carried in tap 0, so each pass of bypass/compare steps bubbles one maximum to the top.
module MED #(
  parameter int SIZE  = 9,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  input  logic             BYP,
  output logic [WIDTH-1:0] DO
);

  logic [WIDTH-1:0] r_tap [SIZE];
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_hi = (r_tap[0] > r_tap[1]) ? r_tap[0] : r_tap[1];
  assign w_lo = (r_tap[0] > r_tap[1]) ? r_tap[1] : r_tap[0];
  assign DO   = r_tap[0];

  // No reset: every window fully reloads the ring before it is sorted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE - 1; i++) begin
      r_tap[i] <= r_tap[i+1];
    end
    if (DSI) begin
      r_tap[SIZE-1] <= DI;
    end else if (BYP) begin
      r_tap[SIZE-1] <= r_tap[0];
    end else begin
      r_tap[0]      <= w_hi;
      r_tap[SIZE-1] <= w_lo;
    end
  end

endmodule

// File: rtl/med_ctrl.sv
// Load-and-sort sequencer for the 9-tap median datapath; registers the median
// with a one-cycle DSO strobe 49 edges after the first pixel.
module med_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             BSY
);

  import med_pkg::*;

  localparam logic [3:0] LAST_CNT  = 4'(N_PIX - 1);
  localparam logic [2:0] LAST_PASS = 3'(N_PASS - 1);
  localparam logic [3:0] LAST_STEP = 4'(LAST_STEPS - 1);

  med_state_t       r_state;
  logic [3:0]       r_cnt;
  logic [2:0]       r_p;
  logic [3:0]       r_s;
  logic [WIDTH-1:0] r_do;
  logic             r_dso;

  logic             w_med_dsi;
  logic             w_med_byp;
  logic [WIDTH-1:0] w_med_do;
  logic [3:0]       w_byp_lim;

  assign w_byp_lim = LAST_CNT - {1'b0, r_p};

  // Pass p compares only the 8-p unsorted taps, then rotates the ring back into alignment.
  always_comb begin
    w_med_dsi = 1'b0;
    w_med_byp = 1'b1;
    case (r_state)
      IDLE, LOAD: w_med_dsi = DSI;
      SORT:       w_med_byp = (r_p == LAST_PASS) ? 1'b0 : !(r_s < w_byp_lim);
      default:    ;
    endcase
  end

  MED #(.SIZE(N_PIX), .WIDTH(WIDTH)) u_med (
    .clk (clk),
    .DI  (DI),
    .DSI (w_med_dsi),
    .BYP (w_med_byp),
    .DO  (w_med_do)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_s     <= '0;
      r_do    <= '0;
      r_dso   <= 1'b0;
    end else begin
      r_dso <= 1'b0;
      case (r_state)
        IDLE: begin
          if (DSI) begin
            r_cnt   <= 4'd1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (DSI) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == LAST_CNT) begin
              r_p     <= '0;
              r_s     <= '0;
              r_state <= SORT;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        SORT: begin
          if (r_p == LAST_PASS) begin
            if (r_s == LAST_STEP) begin
              r_state <= CAPT;
            end else begin
              r_s <= r_s + 4'd1;
            end
          end else if (r_s == LAST_CNT) begin
            r_s <= '0;
            r_p <= r_p + 3'd1;
          end else begin
            r_s <= r_s + 4'd1;
          end
        end
        CAPT: begin
          r_do    <= w_med_do;
          r_dso   <= 1'b1;
          r_cnt   <= '0;
          r_p     <= '0;
          r_s     <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DO  = r_do;
  assign DSO = r_dso;
  assign BSY = (r_state != IDLE);

endmodule

// File: tb/tb_med_ctrl.sv
// Directed and random self-checking bench for med_ctrl (WIDTH=8).
module tb_med_ctrl;

  import med_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] DI;
  logic       DSI;
  logic [7:0] DO;
  logic       DSO;
  logic       BSY;

  int errors = 0;
  int checks = 0;

  med_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .DI  (DI),
    .DSI (DSI),
    .DO  (DO),
    .DSO (DSO),
    .BSY (BSY)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Streams one window starting at the next edge (e0) and observes edges e0..e49.
  task automatic run_window(input logic [7:0] px [9], input bit noise,
                            output int dso_edge, output int n_dso,
                            output logic [7:0] do_val, output bit bsy_ok);
    dso_edge = -1;
    n_dso    = 0;
    do_val   = '0;
    bsy_ok   = 1'b1;
    DI  = px[0];
    DSI = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (DSO === 1'b1) begin
        n_dso++;
        if (dso_edge < 0) dso_edge = k;
        do_val = DO;
      end
      if (BSY !== (k < 49)) bsy_ok = 1'b0;
      if (k < 8) begin
        DI  = px[k+1];
        DSI = 1'b1;
      end else if (noise && k >= 12 && k <= 20) begin
        DI  = 8'hFF;
        DSI = 1'b1;
      end else begin
        DI  = '0;
        DSI = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; DSI = 1'b0; DI = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (DO !== 8'h00) begin errors++; $display("FAIL reset_do: got %h want 00", DO); end
    checks++; if (DSO !== 1'b0) begin errors++; $display("FAIL reset_dso: got %b want 0", DSO); end
    checks++; if (BSY !== 1'b0) begin errors++; $display("FAIL reset_bsy: got %b want 0", BSY); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] w [9];
    int e, n; logic [7:0] d; bit b;
    w = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    run_window(w, 1'b0, e, n, d, b);
    checks++; if (e != MED_LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", e, MED_LAT); end
    checks++; if (n != 1) begin errors++; $display("FAIL basic_dso_count: got %0d want 1", n); end
    checks++; if (d !== 8'd5) begin errors++; $display("FAIL basic_median: got %0d want 5", d); end
    checks++; if (!b) begin errors++; $display("FAIL basic_bsy: got bad profile want high e0..e48"); end
    @(posedge clk); #1;
    checks++; if (DSO !== 1'b0) begin errors++; $display("FAIL basic_dso_width: got %b want 0", DSO); end
    checks++; if (DO !== 8'd5) begin errors++; $display("FAIL basic_do_hold: got %0d want 5", DO); end
  endtask

  task automatic test_abort();
    logic [7:0] w [9];
    int e, n; logic [7:0] d; bit b;
    int n_abort = 0;
    DI = 8'd200; DSI = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (DSO === 1'b1) n_abort++;
      if (k == 4) begin DSI = 1'b0; DI = '0; end
    end
    checks++; if (n_abort != 0) begin errors++; $display("FAIL abort_dso: got %0d pulses want 0", n_abort); end
    checks++; if (DO !== 8'd5) begin errors++; $display("FAIL abort_do_kept: got %0d want 5", DO); end
    checks++; if (BSY !== 1'b0) begin errors++; $display("FAIL abort_idle: got bsy %b want 0", BSY); end
    w = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    run_window(w, 1'b0, e, n, d, b);
    checks++; if (d !== 8'd50 || n != 1) begin errors++; $display("FAIL abort_next_median: got %0d (%0d pulses) want 50 (1)", d, n); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1 [9];
    logic [7:0] w2 [9];
    int e1, n1, e2, n2; logic [7:0] d1, d2; bit b1, b2;
    w1 = '{default: 8'h80};
    w2 = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_window(w1, 1'b0, e1, n1, d1, b1);
    run_window(w2, 1'b0, e2, n2, d2, b2);
    checks++; if (d1 !== 8'h80) begin errors++; $display("FAIL b2b_median1: got %h want 80", d1); end
    checks++; if (d2 !== 8'h00) begin errors++; $display("FAIL b2b_median2: got %h want 00", d2); end
    checks++; if (e1 != 49 || e2 != 49 || n1 != 1 || n2 != 1) begin
      errors++; $display("FAIL b2b_dso_spacing: got edges %0d,%0d counts %0d,%0d want 49,49 1,1", e1, e2, n1, n2);
    end
    checks++; if (!b1 || !b2) begin errors++; $display("FAIL b2b_bsy: got %b%b want 11", b1, b2); end
  endtask

  task automatic test_sort_noise();
    logic [7:0] w [9];
    int e, n; logic [7:0] d; bit b;
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    run_window(w, 1'b1, e, n, d, b);
    checks++; if (d !== 8'd5) begin errors++; $display("FAIL noise_median: got %0d want 5", d); end
    checks++; if (e != 49 || n != 1) begin errors++; $display("FAIL noise_dso: got edge %0d count %0d want 49 1", e, n); end
  endtask

  task automatic test_rst_mid_sort();
    logic [7:0] w [9];
    int e, n; logic [7:0] d; bit b;
    w = '{8'd200, 8'd10, 8'd150, 8'd30, 8'd120, 8'd60, 8'd90, 8'd80, 8'd100};
    DI = w[0]; DSI = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k < 8) DI = w[k+1];
      else begin DSI = 1'b0; DI = '0; end
    end
    checks++; if (BSY !== 1'b1) begin errors++; $display("FAIL rst_pre_bsy: got %b want 1", BSY); end
    rst = 1'b1;
    #1;
    checks++; if (BSY !== 1'b0) begin errors++; $display("FAIL rst_async_bsy: got %b want 0", BSY); end
    checks++; if (DSO !== 1'b0) begin errors++; $display("FAIL rst_async_dso: got %b want 0", DSO); end
    checks++; if (DO !== 8'd0) begin errors++; $display("FAIL rst_async_do: got %0d want 0", DO); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // Sorted: 10 30 60 80 90 100 120 150 200 -> fifth value is 90.
    run_window(w, 1'b0, e, n, d, b);
    checks++; if (d !== 8'd90 || e != 49) begin errors++; $display("FAIL rst_next_median: got %0d at edge %0d want 90 at 49", d, e); end
  endtask

  task automatic test_random();
    logic [7:0] w [9];
    int srt [9];
    int e, n, t, bad_dso; logic [7:0] d; bit b;
    bad_dso = 0;
    for (int it = 0; it < 1000; it++) begin
      for (int i = 0; i < 9; i++) begin
        w[i]   = 8'($urandom_range(0, 255));
        srt[i] = int'(w[i]);
      end
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8 - i; j++)
          if (srt[j] > srt[j+1]) begin t = srt[j]; srt[j] = srt[j+1]; srt[j+1] = t; end
      run_window(w, 1'b0, e, n, d, b);
      checks++;
      if (d !== 8'(srt[4])) begin
        errors++; $display("FAIL random_median[%0d]: got %0d want %0d", it, d, srt[4]);
      end
      if (n != 1 || e != 49) bad_dso++;
    end
    checks++; if (bad_dso != 0) begin errors++; $display("FAIL random_dso: got %0d bad windows want 0", bad_dso); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_back_to_back();
    test_sort_noise();
    test_rst_mid_sort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
